// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch line buffer: FSM states, the Sysbus
// read tag and the line-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } fetch_state_t;

    localparam logic        READ          = 1'b1;
    localparam logic [3:0]  MEMORY        = 4'b0001;
    localparam logic [12:0] FETCH_REQ_TAG = {READ, MEMORY, 8'b0};

    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte store for the fetch line buffer: beat-wide write port, wrapping
// decode-window read port, and the read/write pointers.
module fetch_byte_ring #(
    parameter int BUF_BYTES  = 128,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BYTES = 8,
    parameter int WIN_BYTES  = 15,
    localparam int PW        = $clog2(BUF_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    wr_en_i,
    input  logic [8*BEAT_BYTES-1:0] wr_data_i,
    input  logic [PW-1:0]           rd_adv_i,
    output logic [8*WIN_BYTES-1:0]  win_o
);

    if (BUF_BYTES < 2 * LINE_BYTES) begin : g_bad_depth
        $error("fetch_byte_ring: BUF_BYTES must be at least 2*LINE_BYTES");
    end

    logic [7:0]    mem_q [BUF_BYTES];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;

    // NOTE: the storage is cleared on reset because the decode window must read
    // as all-zero right after reset; this costs a reset net on every byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                for (int i = 0; i < BEAT_BYTES; i++) begin
                    mem_q[wr_ptr_q + PW'(i)] <= wr_data_i[8*i +: 8];
                end
                wr_ptr_q <= wr_ptr_q + PW'(BEAT_BYTES);
            end
            rd_ptr_q <= rd_ptr_q + rd_adv_i;
        end
    end

    // Index arithmetic is PW bits wide, so the window wraps past the buffer end.
    always_comb begin
        win_o = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            win_o[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

endmodule

// File: rtl/fetch_line_buffer.sv
// Front-end fetch: line requests over Sysbus into a circular byte ring feeding a
// fixed decode window. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES  = 128,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BYTES = 8,
    parameter int WIN_BYTES  = 15,
    localparam int CW        = $clog2(WIN_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [63:0]             entry,
    output logic                    reqcyc,
    output logic [63:0]             req,
    output logic [12:0]             reqtag,
    input  logic                    reqack,
    input  logic                    respcyc,
    input  logic [8*BEAT_BYTES-1:0] resp,
    output logic                    respack,
    input  logic                    redirect_valid,
    input  logic [63:0]             redirect_rip,
    output logic                    dec_valid,
    output logic [8*WIN_BYTES-1:0]  dec_bytes,
    output logic [63:0]             dec_rip,
    input  logic [CW-1:0]           dec_consume
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_stall,
    output logic [31:0]             perf_lines,
    output logic [31:0]             perf_redirects
`endif
);

    localparam int OW     = $clog2(BUF_BYTES) + 1;
    localparam int PW     = $clog2(BUF_BYTES);
    localparam int SW     = $clog2(LINE_BYTES);
    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    fetch_state_t  state_q, state_d;
    logic          reqcyc_q, reqcyc_d;
    logic [63:0]   req_q, req_d;
    logic [63:0]   fetch_rip_q, fetch_rip_d;
    logic [63:0]   dec_rip_q, dec_rip_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          discard_q, discard_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic          beat_fire;
    logic          last_beat;
    logic          consume_ok;
    logic          ring_flush;
    logic          ring_wr_en;
    logic [PW-1:0] ring_rd_adv;
    logic [OW-1:0] occ_add;
    logic [OW-1:0] occ_sub;

    assign beat_fire  = (state_q == RESP) && respcyc;
    assign last_beat  = beat_fire && (beat_cnt_q == BW'(NBEATS - 1));
    assign dec_valid  = (occ_q >= OW'(WIN_BYTES)) && !redirect_valid;
    assign consume_ok = dec_valid && (32'(dec_consume) <= WIN_BYTES);

    // NOTE: every signal gets its hold/default value first so no path through
    // the block leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        reqcyc_d    = reqcyc_q;
        req_d       = req_q;
        fetch_rip_d = fetch_rip_q;
        dec_rip_d   = dec_rip_q;
        skip_d      = skip_q;
        discard_d   = discard_q;
        beat_cnt_d  = beat_cnt_q;
        ring_flush  = 1'b0;
        ring_wr_en  = 1'b0;
        ring_rd_adv = '0;
        occ_add     = '0;
        occ_sub     = '0;

        case (state_q)
            IDLE: begin
                if (occ_q <= OW'(BUF_BYTES - LINE_BYTES) && !redirect_valid) begin
                    state_d  = REQ;
                    reqcyc_d = 1'b1;
                    req_d    = fetch_rip_q;
                end
            end
            REQ: begin
                if (reqack) begin
                    state_d  = RESP;
                    reqcyc_d = 1'b0;
                end
            end
            RESP: begin
                if (respcyc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        discard_d  = 1'b0;
                        if (!discard_q) begin
                            fetch_rip_d = fetch_rip_q + 64'(LINE_BYTES);
                        end
                    end
                    // Whole beats before the start offset are dropped; the
                    // leftover sub-beat offset is skipped by advancing rd_ptr.
                    if (!discard_q && !redirect_valid) begin
                        if (32'(skip_q) >= BEAT_BYTES) begin
                            skip_d = skip_q - SW'(BEAT_BYTES);
                        end else begin
                            ring_wr_en  = 1'b1;
                            occ_add     = OW'(BEAT_BYTES) - OW'(skip_q);
                            ring_rd_adv = PW'(skip_q);
                            skip_d      = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume_ok) begin
            ring_rd_adv = ring_rd_adv + PW'(dec_consume);
            dec_rip_d   = dec_rip_q + 64'(dec_consume);
            occ_sub     = OW'(dec_consume);
        end
        occ_d = occ_q + occ_add - occ_sub;

        // Redirect is evaluated last so it overrides consume and beat writes.
        // A line ending this very cycle needs no discard for the next one.
        if (redirect_valid) begin
            ring_flush  = 1'b1;
            ring_wr_en  = 1'b0;
            ring_rd_adv = '0;
            occ_d       = '0;
            fetch_rip_d = line_align(redirect_rip, LINE_BYTES);
            skip_d      = SW'(redirect_rip);
            dec_rip_d   = redirect_rip;
            discard_d   = (state_q == REQ) || (state_q == RESP && !last_beat);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            reqcyc_q    <= 1'b0;
            req_q       <= '0;
            fetch_rip_q <= line_align(entry, LINE_BYTES);
            dec_rip_q   <= entry;
            occ_q       <= '0;
            skip_q      <= SW'(entry);
            discard_q   <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            reqcyc_q    <= reqcyc_d;
            req_q       <= req_d;
            fetch_rip_q <= fetch_rip_d;
            dec_rip_q   <= dec_rip_d;
            occ_q       <= occ_d;
            skip_q      <= skip_d;
            discard_q   <= discard_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    fetch_byte_ring #(
        .BUF_BYTES (BUF_BYTES),
        .LINE_BYTES(LINE_BYTES),
        .BEAT_BYTES(BEAT_BYTES),
        .WIN_BYTES (WIN_BYTES)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (ring_flush),
        .wr_en_i  (ring_wr_en),
        .wr_data_i(resp),
        .rd_adv_i (ring_rd_adv),
        .win_o    (dec_bytes)
    );

    assign reqcyc  = reqcyc_q;
    assign req     = req_q;
    assign reqtag  = FETCH_REQ_TAG;
    assign respack = respcyc;
    assign dec_rip = dec_rip_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        ring_wr_en |-> (32'(occ_q) + BEAT_BYTES <= BUF_BYTES));

    a_consume_range: assert property (@(posedge clk) disable iff (!reset)
        dec_valid |-> (32'(dec_consume) <= WIN_BYTES));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_lines_q;
    logic [31:0] perf_redirects_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q     <= '0;
            perf_lines_q     <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (!dec_valid) perf_stall_q <= perf_stall_q + 32'd1;
            if (last_beat && !discard_q && !redirect_valid) perf_lines_q <= perf_lines_q + 32'd1;
            if (redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
        end
    end

    assign perf_stall     = perf_stall_q;
    assign perf_lines     = perf_lines_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: bus served by tasks, consume phases
// driven from a vector table, redirect/reset corner cases hand-sequenced.
module tb_fetch_line_buffer;
    import fetch_pkg::*;

    localparam int WIN  = 15;
    localparam int BEAT = 8;

    logic              clk;
    logic              reset;
    logic [63:0]       entry;
    logic              reqcyc;
    logic [63:0]       req;
    logic [12:0]       reqtag;
    logic              reqack;
    logic              respcyc;
    logic [8*BEAT-1:0] resp;
    logic              respack;
    logic              redirect_valid;
    logic [63:0]       redirect_rip;
    logic              dec_valid;
    logic [8*WIN-1:0]  dec_bytes;
    logic [63:0]       dec_rip;
    logic [3:0]        dec_consume;

    fetch_line_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .entry         (entry),
        .reqcyc        (reqcyc),
        .req           (req),
        .reqtag        (reqtag),
        .reqack        (reqack),
        .respcyc       (respcyc),
        .resp          (resp),
        .respack       (respack),
        .redirect_valid(redirect_valid),
        .redirect_rip  (redirect_rip),
        .dec_valid     (dec_valid),
        .dec_bytes     (dec_bytes),
        .dec_rip       (dec_rip),
        .dec_consume   (dec_consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  consume;
        logic        exp_valid;
        logic [63:0] exp_rip;
    } vec_t;

    vec_t tab_a [5];
    vec_t tab_b [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Backing memory model: every address holds a distinct-looking byte.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [8*WIN-1:0] exp_win(input logic [63:0] rip);
        logic [8*WIN-1:0] w;
        for (int i = 0; i < WIN; i++) w[8*i +: 8] = mem_byte(rip + 64'(i));
        return w;
    endfunction

    function automatic logic [8*BEAT-1:0] beat_data(input logic [63:0] addr);
        logic [8*BEAT-1:0] d;
        for (int i = 0; i < BEAT; i++) d[8*i +: 8] = mem_byte(addr + 64'(i));
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [63:0] exp_addr);
        for (int i = 0; i < 50 && !reqcyc; i++) tick();
        check("req_seen", reqcyc, 1'b1);
        check("req_addr", req, exp_addr);
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        check("reqcyc_drop_after_ack", reqcyc, 1'b0);
    endtask

    task automatic send_beat(input logic [63:0] addr);
        respcyc = 1'b1;
        resp    = beat_data(addr);
        tick();
        respcyc = 1'b0;
    endtask

    task automatic send_beats(input logic [63:0] line, input int first, input int last);
        for (int b = first; b <= last; b++) send_beat(line + 64'(8 * b));
    endtask

    task automatic run_vec(input vec_t v);
        dec_consume = v.consume;
        tick();
        dec_consume = '0;
        check("tab_valid", dec_valid, v.exp_valid);
        check("tab_rip", dec_rip, v.exp_rip);
        if (v.exp_valid) check("tab_window", dec_bytes, exp_win(v.exp_rip));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;

        tab_a[0] = '{4'd15, 1'b1, 64'h100F};
        tab_a[1] = '{4'd15, 1'b1, 64'h101E};
        tab_a[2] = '{4'd15, 1'b1, 64'h102D};
        tab_a[3] = '{4'd15, 1'b1, 64'h103C};
        tab_a[4] = '{4'd5,  1'b1, 64'h1041};
        tab_b[0] = '{4'd15, 1'b1, 64'h1050};
        tab_b[1] = '{4'd15, 1'b1, 64'h105F};
        tab_b[2] = '{4'd15, 1'b1, 64'h106E};
        tab_b[3] = '{4'd15, 1'b1, 64'h107D};
        tab_b[4] = '{4'd1,  1'b1, 64'h107E};
        tab_b[5] = '{4'd0,  1'b1, 64'h107E};
        tab_b[6] = '{4'd15, 1'b1, 64'h108D};

        reset = 1'b0; entry = 64'h1000; reqack = 1'b0; respcyc = 1'b0; resp = '0;
        redirect_valid = 1'b0; redirect_rip = '0; dec_consume = '0;
        repeat (3) tick();

        check("rst_reqcyc", reqcyc, 1'b0);
        check("rst_req", req, 64'h0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_rip", dec_rip, 64'h1000);
        check("rst_dec_bytes", dec_bytes, '0);
        check("reqtag", reqtag, {READ, MEMORY, 8'b0});
        respcyc = 1'b1; #1;
        check("respack_hi", respack, 1'b1);
        respcyc = 1'b0; #1;
        check("respack_lo", respack, 1'b0);
        reset = 1'b1;

        // Sequential fill from 0x1000: window opens after two beats.
        wait_req(64'h1000);
        send_beat(64'h1000);
        check("valid_after_1beat", dec_valid, 1'b0);
        send_beat(64'h1008);
        check("valid_after_2beats", dec_valid, 1'b1);
        check("rip_after_2beats", dec_rip, 64'h1000);
        check("window_0x1000", dec_bytes, exp_win(64'h1000));
        send_beats(64'h1000, 2, 7);
        wait_req(64'h1040);
        send_beats(64'h1040, 0, 7);

        // Full buffer with no consumption: no third request.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (reqcyc) cnt++;
        end
        check("no_third_request", 32'(cnt), 32'd0);
        check("full_window", dec_bytes, exp_win(64'h1000));

        for (int i = 0; i < 5; i++) run_vec(tab_a[i]);
        wait_req(64'h1080);
        send_beats(64'h1080, 0, 7);
        for (int i = 0; i < 7; i++) run_vec(tab_b[i]);

        // Redirect during beat 3 of the next line.
        wait_req(64'h10C0);
        send_beats(64'h10C0, 0, 2);
        redirect_valid = 1'b1; redirect_rip = 64'h2008;
        #1;
        check("valid_masked_by_redirect", dec_valid, 1'b0);
        respcyc = 1'b1; resp = beat_data(64'h10D8);
        tick();
        respcyc = 1'b0; redirect_valid = 1'b0;
        check("redir_valid", dec_valid, 1'b0);
        check("redir_rip", dec_rip, 64'h2008);
        send_beats(64'h10C0, 4, 7);
        check("dropped_beats_valid", dec_valid, 1'b0);
        wait_req(64'h2000);
        send_beat(64'h2000);
        check("skipped_beat_valid", dec_valid, 1'b0);
        send_beats(64'h2000, 1, 2);
        check("redir_line_valid", dec_valid, 1'b1);
        check("redir_line_rip", dec_rip, 64'h2008);
        check("redir_line_window", dec_bytes, exp_win(64'h2008));
        send_beats(64'h2000, 3, 7);

        // Asynchronous reset in the middle of a response.
        wait_req(64'h2040);
        send_beats(64'h2040, 0, 1);
        reset = 1'b0; entry = 64'h3000;
        #1;
        check("midrst_reqcyc", reqcyc, 1'b0);
        check("midrst_req", req, 64'h0);
        check("midrst_valid", dec_valid, 1'b0);
        check("midrst_rip", dec_rip, 64'h3000);
        check("midrst_bytes", dec_bytes, '0);
        tick(); tick();
        reset = 1'b1;
        wait_req(64'h3000);
        send_beat(64'h3000);
        dec_consume = 4'd4;
        send_beat(64'h3008);
        dec_consume = 4'd0;
        check("consume_ignored_rip", dec_rip, 64'h3000);
        check("consume_ignored_valid", dec_valid, 1'b1);
        dec_consume = 4'd10;
        send_beat(64'h3010);
        dec_consume = 4'd0;
        check("write_and_consume_rip", dec_rip, 64'h300A);
        check("write_and_consume_valid", dec_valid, 1'b0);
        send_beat(64'h3018);
        check("after_wc_valid", dec_valid, 1'b1);
        check("after_wc_window", dec_bytes, exp_win(64'h300A));
        send_beats(64'h3000, 4, 7);

        // Unaligned entry: two whole beats dropped, three bytes skipped.
        reset = 1'b0; entry = 64'h1013;
        tick(); tick();
        reset = 1'b1;
        wait_req(64'h1000);
        send_beats(64'h1000, 0, 1);
        check("unal_skip_valid", dec_valid, 1'b0);
        send_beats(64'h1000, 2, 3);
        check("unal_13bytes_valid", dec_valid, 1'b0);
        send_beat(64'h1020);
        check("unal_valid", dec_valid, 1'b1);
        check("unal_rip", dec_rip, 64'h1013);
        check("unal_window", dec_bytes, exp_win(64'h1013));
        send_beats(64'h1000, 5, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
